// File: rtl/alu_op_pkg.sv
// Shared ALU op codes, FSM state encoding and shift-kind helpers.
// The ALU controller also imports this package.
package alu_op_pkg;

    typedef enum logic [3:0] {
        OpAnd = 4'b0000,
        OpOr  = 4'b0001,
        OpAdd = 4'b0010,
        OpXor = 4'b0011,
        OpSll = 4'b0100,
        OpSrl = 4'b0101,
        OpSub = 4'b0110,
        OpSra = 4'b0111,
        OpEq  = 4'b1000,
        OpSlt = 4'b1100
    } alu_op_e;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StShift = 2'b01,
        StDone  = 2'b10
    } alu_state_e;

    // Shift kind is the low two bits of the shift op code.
    localparam logic [1:0] KindSll = 2'b00;
    localparam logic [1:0] KindSrl = 2'b01;
    localparam logic [1:0] KindSra = 2'b11;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OpSll) || (op == OpSrl) || (op == OpSra);
    endfunction

endpackage

// File: rtl/alu_shift_step.sv
// One iteration of the multi-cycle shifter: shifts by k_i bits (0..SHIFT_STEP).
module alu_shift_step
    import alu_op_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SHIFT_STEP = 1,
    localparam int unsigned SW = $clog2(SHIFT_STEP + 1)
) (
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [SW-1:0]         k_i,
    input  logic [1:0]            kind_i,
    output logic [DATA_WIDTH-1:0] y_o
);

    always_comb begin
        y_o = a_i;
        case (kind_i)
            KindSll: y_o = a_i << k_i;
            KindSrl: y_o = a_i >> k_i;
            KindSra: y_o = $signed(a_i) >>> k_i;
            default: y_o = a_i;
        endcase
    end

endmodule

// File: rtl/alu_seq_exec.sv
// Execute-stage ALU with valid/ready handshakes; single-cycle logic/arith/compare
// and an iterative shifter advancing up to SHIFT_STEP bits per cycle.
module alu_seq_exec
    import alu_op_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SHIFT_STEP = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            Operation,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] ALUResult,
    output logic                  Zero,
    output logic                  illegal
);

    localparam int unsigned CW = $clog2(DATA_WIDTH);
    localparam int unsigned SW = $clog2(SHIFT_STEP + 1);

    alu_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic                  zero_q, zero_d;
    logic                  illegal_q, illegal_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [1:0]            kind_q, kind_d;

    logic [CW-1:0]         shamt;
    logic [SW-1:0]         step_k;
    logic [CW-1:0]         cnt_next;
    logic [DATA_WIDTH-1:0] shift_y;
    logic [DATA_WIDTH-1:0] alu_res;
    logic                  alu_illegal;

    assign shamt = SrcB[CW-1:0];

    always_comb begin
        alu_res     = '0;
        alu_illegal = 1'b0;
        case (alu_op_e'(Operation))
            OpAnd: alu_res = SrcA & SrcB;
            OpOr:  alu_res = SrcA | SrcB;
            OpAdd: alu_res = SrcA + SrcB;
            OpXor: alu_res = SrcA ^ SrcB;
            OpSub: alu_res = SrcA - SrcB;
            OpEq:  alu_res = DATA_WIDTH'(SrcA == SrcB);
            OpSlt: alu_res = DATA_WIDTH'($signed(SrcA) < $signed(SrcB));
            OpSll, OpSrl, OpSra: alu_res = '0;
            default: alu_illegal = 1'b1;
        endcase
    end

    // k = min(cnt, SHIFT_STEP); compared at full int width so small DATA_WIDTH is safe.
    always_comb begin
        if (32'(cnt_q) > SHIFT_STEP) begin
            step_k = SW'(SHIFT_STEP);
        end else begin
            step_k = SW'(cnt_q);
        end
        cnt_next = cnt_q - CW'(step_k);
    end

    alu_shift_step #(
        .DATA_WIDTH (DATA_WIDTH),
        .SHIFT_STEP (SHIFT_STEP)
    ) u_shift_step (
        .a_i    (res_q),
        .k_i    (step_k),
        .kind_i (kind_q),
        .y_o    (shift_y)
    );

    always_comb begin
        state_d   = state_q;
        res_d     = res_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;
        kind_d    = kind_q;
        if (flush) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        illegal_d = 1'b0;
                        if (is_shift_op(Operation)) begin
                            kind_d = Operation[1:0];
                            res_d  = SrcA;
                            if (shamt == '0) begin
                                zero_d  = (SrcA == '0);
                                state_d = StDone;
                            end else begin
                                cnt_d   = shamt;
                                state_d = StShift;
                            end
                        end else begin
                            res_d     = alu_res;
                            zero_d    = (alu_res == '0);
                            illegal_d = alu_illegal;
                            state_d   = StDone;
                        end
                    end
                end
                StShift: begin
                    res_d = shift_y;
                    cnt_d = cnt_next;
                    if (cnt_next == '0) begin
                        zero_d  = (shift_y == '0);
                        state_d = StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            res_q     <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
            kind_q    <= KindSll;
        end else begin
            state_q   <= state_d;
            res_q     <= res_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
            kind_q    <= kind_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign ALUResult = res_q;
    assign Zero      = zero_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Directed, table-driven bench for alu_seq_exec (SHIFT_STEP=1 and SHIFT_STEP=4 instances).
module tb_alu_seq_exec;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0, in_valid4 = 1'b0;
    logic        out_ready = 1'b0, out_ready4 = 1'b0;
    logic [3:0]  Operation = 4'h0;
    logic [31:0] SrcA = '0, SrcB = '0;
    logic        in_ready, out_valid, Zero, illegal;
    logic [31:0] ALUResult;
    logic        in_ready4, out_valid4, Zero4, illegal4;
    logic [31:0] ALUResult4;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    alu_seq_exec #(.DATA_WIDTH(32), .SHIFT_STEP(1)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .Operation(Operation), .SrcA(SrcA), .SrcB(SrcB),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALUResult(ALUResult), .Zero(Zero), .illegal(illegal)
    );

    alu_seq_exec #(.DATA_WIDTH(32), .SHIFT_STEP(4)) dut4 (
        .clk(clk), .reset(reset), .flush(1'b0),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .Operation(Operation), .SrcA(SrcA), .SrcB(SrcB),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .ALUResult(ALUResult4), .Zero(Zero4), .illegal(illegal4)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
        logic        ill;
        int          lat;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op to the selected instance, measure accept-to-out_valid latency,
    // capture outputs, then consume the result.
    task automatic issue(input bit sel, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int lat, output logic [31:0] res,
                         output logic zero, output logic ill);
        int guard = 0;
        while (!(sel ? in_ready4 : in_ready) && guard < 50) begin
            tick();
            guard++;
        end
        Operation = op;
        SrcA = a;
        SrcB = b;
        if (sel) in_valid4 = 1'b1; else in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_valid4 = 1'b0;
        lat = 1;
        while (!(sel ? out_valid4 : out_valid) && lat < 100) begin
            tick();
            lat++;
        end
        res  = sel ? ALUResult4 : ALUResult;
        zero = sel ? Zero4 : Zero;
        ill  = sel ? illegal4 : illegal;
        if (sel) out_ready4 = 1'b1; else out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        out_ready4 = 1'b0;
    endtask

    initial begin
        int          lat;
        int          rises;
        logic [31:0] res;
        logic        zero, ill;

        vecs[0]  = '{4'h2, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1};
        vecs[1]  = '{4'h6, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1};
        vecs[2]  = '{4'hC, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1};
        vecs[3]  = '{4'h8, 32'h00000007, 32'h00000007, 32'h00000001, 1'b0, 1'b0, 1};
        vecs[4]  = '{4'h0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1};
        vecs[5]  = '{4'h1, 32'h0000000F, 32'h000000F0, 32'h000000FF, 1'b0, 1'b0, 1};
        vecs[6]  = '{4'h3, 32'hA5A5A5A5, 32'hFFFFFFFF, 32'h5A5A5A5A, 1'b0, 1'b0, 1};
        vecs[7]  = '{4'h4, 32'h12345678, 32'h00000000, 32'h12345678, 1'b0, 1'b0, 1};
        vecs[8]  = '{4'hF, 32'h12345678, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1};
        vecs[9]  = '{4'h5, 32'h80000000, 32'h00000004, 32'h08000000, 1'b0, 1'b0, 5};
        vecs[10] = '{4'h4, 32'h00000001, 32'h00000003, 32'h00000008, 1'b0, 1'b0, 4};
        vecs[11] = '{4'h7, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 1'b0, 1'b0, 32};
        vecs[12] = '{4'h8, 32'h00000007, 32'h00000008, 32'h00000000, 1'b1, 1'b0, 1};
        vecs[13] = '{4'hC, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1};
        vecs[14] = '{4'h2, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1};
        vecs[15] = '{4'h9, 32'h00000001, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1};
        vecs[16] = '{4'h4, 32'h00000003, 32'h00000021, 32'h00000006, 1'b0, 1'b0, 2};

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_result", ALUResult, 32'h0);
        check("reset_zero", 32'(Zero), 32'd1);
        check("reset_illegal", 32'(illegal), 32'd0);

        for (int i = 0; i < NV; i++) begin
            issue(1'b0, vecs[i].op, vecs[i].a, vecs[i].b, lat, res, zero, ill);
            check($sformatf("vec%0d_result", i), res, vecs[i].res);
            check($sformatf("vec%0d_zero", i), 32'(zero), 32'(vecs[i].zero));
            check($sformatf("vec%0d_illegal", i), 32'(ill), 32'(vecs[i].ill));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
        end

        // SHIFT_STEP=4: 31-bit arithmetic shift takes 1+ceil(31/4) cycles.
        issue(1'b1, 4'h7, 32'h80000000, 32'd31, lat, res, zero, ill);
        check("step4_sra_result", res, 32'hFFFFFFFF);
        check("step4_sra_latency", 32'(lat), 32'd9);

        // Backpressure: result and handshake lines hold while out_ready is low.
        Operation = 4'h2;
        SrcA = 32'd2;
        SrcB = 32'd3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp%0d_result", c), ALUResult, 32'd5);
            check($sformatf("bp%0d_in_ready", c), 32'(in_ready), 32'd0);
            check($sformatf("bp%0d_out_valid", c), 32'(out_valid), 32'd1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_out_valid", 32'(out_valid), 32'd0);

        // Flush partway through a 10-cycle SLL: no result may appear.
        Operation = 4'h4;
        SrcA = 32'd1;
        SrcB = 32'd9;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        rises = 0;
        for (int c = 0; c < 15; c++) begin
            if (out_valid) rises++;
            tick();
        end
        check("flush_no_out_valid", 32'(rises), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        issue(1'b0, 4'h2, 32'd2, 32'd3, lat, res, zero, ill);
        check("post_flush_add", res, 32'd5);
        check("post_flush_latency", 32'(lat), 32'd1);

        // Same with reset: outputs return to and hold reset values.
        Operation = 4'h4;
        SrcA = 32'd1;
        SrcB = 32'd9;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rises = 0;
        for (int c = 0; c < 15; c++) begin
            if (out_valid) rises++;
            tick();
        end
        check("reset_mid_no_out_valid", 32'(rises), 32'd0);
        check("reset_mid_result", ALUResult, 32'h0);
        check("reset_mid_zero", 32'(Zero), 32'd1);
        check("reset_mid_illegal", 32'(illegal), 32'd0);
        issue(1'b0, 4'h2, 32'd2, 32'd3, lat, res, zero, ill);
        check("post_reset_add", res, 32'd5);
        check("post_reset_zero", 32'(zero), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
